// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request and register-file write-back bundle for mdu_iter
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [4:0]      rd;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic            Reg_Write;
  logic [4:0]      W_Addr;
  logic [XLEN-1:0] W_Data;

  modport master (
    output start, op, rd, A, B,
    input  busy, done, Reg_Write, W_Addr, W_Data
  );

  modport slave (
    input  start, op, rd, A, B,
    output busy, done, Reg_Write, W_Addr, W_Data
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative unsigned multiply/divide unit with register-file write-back
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic        clk_Regs,
  input  logic        clk_rst,
  mdu_iter_if.slave   bus
);
  localparam int             CW   = $clog2(STEPS);
  localparam logic [CW-1:0]  LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_d;
  logic   accept;
  logic   last_step;

  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] b_q;
  // hi/lo hold the product halves for multiply and rem/quo for divide
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_s;
  logic [XLEN:0]   sub;
  logic            fits;

  logic            busy_q;
  logic            done_q;
  logic            wr_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk_Regs or negedge clk_rst) begin
    if (!clk_rst) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state decode: accept only in IDLE, fixed STEPS iterations, one DONE cycle
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    last_step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST) begin
          last_step = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration: shift-add multiply step or restoring-divide step
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    // The shifted remainder can reach XLEN+1 bits; a set top bit always fits
    rem_s   = {hi, lo[XLEN-1]};
    sub     = {1'b0, rem_s[XLEN-1:0]} - {1'b0, b_q};
    fits    = rem_s[XLEN] | ~sub[XLEN];
    if (!op_q[1]) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end else if (fits) begin
      hi_n = sub[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_n = rem_s[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b0};
    end
  end

  // Operand latch on accept, then one datapath step per RUN cycle
  always_ff @(posedge clk_Regs or negedge clk_rst) begin
    if (!clk_rst) begin
      cnt  <= '0;
      op_q <= '0;
      rd_q <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= bus.op;
      rd_q <= bus.rd;
      b_q  <= bus.B;
      hi   <= '0;
      lo   <= bus.A;
    end else if (state == S_RUN) begin
      cnt  <= cnt + 1'b1;
      hi   <= hi_n;
      lo   <= lo_n;
    end
  end

  // Registered status and write-back; the result is captured from the final step
  always_ff @(posedge clk_Regs or negedge clk_rst) begin
    if (!clk_rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      wr_q   <= (state_d == S_DONE) && (rd_q != 5'd0);
      if (last_step) begin
        waddr_q <= rd_q;
        // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half
        wdata_q <= op_q[0] ? hi_n : lo_n;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Reg_Write = wr_q;
  assign bus.W_Addr    = waddr_q;
  assign bus.W_Data    = wdata_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if bus ();

  mdu_iter dut (
    .clk_Regs (clk),
    .clk_rst  (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Register file fed by the write-back port
  logic [31:0] rf [32];
  int          wr_count = 0;
  always @(posedge clk) begin
    if (bus.Reg_Write) begin
      rf[bus.W_Addr] <= bus.W_Data;
      wr_count       <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Counts edges from the current point until done is seen (bounded)
  task automatic wait_done(output int k, output bit busy_ok);
    k = 0;
    busy_ok = 1'b1;
    while (k < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic check_done(input string tag, input int k, input bit busy_ok,
                            input logic [4:0] r, input logic [31:0] exp);
    check({tag, "_latency"}, 64'(k), 64'(32));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
    check({tag, "_W_Data"}, 64'(bus.W_Data), 64'(exp));
    check({tag, "_W_Addr"}, 64'(bus.W_Addr), 64'(r));
    check({tag, "_Reg_Write"}, 64'(bus.Reg_Write), 64'(r != 5'd0));
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    int          k;
    int          w0;
    bit          busy_ok;
    logic [31:0] exp;
    exp = ref_result(o, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rd = r; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    check({tag, "_busy_on_accept"}, 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.rd = 5'($urandom); bus.A = $urandom; bus.B = $urandom;
    w0 = wr_count;
    wait_done(k, busy_ok);
    check_done(tag, k, busy_ok, r, exp);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 64'({bus.busy, bus.done, bus.Reg_Write}), 64'(0));
    check({tag, "_writes"}, 64'(wr_count - w0), 64'(r != 5'd0));
    if (r != 5'd0) check({tag, "_rf"}, 64'(rf[r]), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          w0;
    bit          busy_ok;
    bit          stray;
    logic [1:0]  o;
    logic [4:0]  r;
    logic [31:0] a;
    logic [31:0] b;

    bus.start = 1'b0; bus.op = 2'd0; bus.rd = 5'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.busy, bus.done, bus.Reg_Write, bus.W_Addr, bus.W_Data}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pulled mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.rd = 5'd9; bus.A = 32'd7; bus.B = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({bus.busy, bus.done, bus.Reg_Write, bus.W_Addr, bus.W_Data}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_count;
    stray = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (bus.Reg_Write !== 1'b0 || bus.done !== 1'b0) stray = 1'b1;
    end
    check("abort_no_done", 64'(stray), 64'(0));
    check("abort_no_write", 64'(wr_count - w0), 64'(0));
    do_op("mul_after_abort", 2'd0, 5'd9, 32'd7, 32'd6);

    // Directed corner cases
    do_op("mul_ff", 2'd0, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_ff_const", 64'(rf[5]), 64'h0000_0001);
    do_op("mulhu_ff", 2'd1, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_ff_const", 64'(rf[5]), 64'hFFFF_FFFE);
    do_op("divu_100_7", 2'd2, 5'd3, 32'd100, 32'd7);
    check("divu_100_7_const", 64'(rf[3]), 64'd14);
    do_op("remu_100_7", 2'd3, 5'd3, 32'd100, 32'd7);
    check("remu_100_7_const", 64'(rf[3]), 64'd2);
    do_op("divu_msb", 2'd2, 5'd4, 32'h8000_0000, 32'd1);
    check("divu_msb_const", 64'(rf[4]), 64'h8000_0000);
    do_op("divu_zero", 2'd2, 5'd6, 32'h1234, 32'd0);
    check("divu_zero_const", 64'(rf[6]), 64'hFFFF_FFFF);
    do_op("remu_zero", 2'd3, 5'd6, 32'h1234, 32'd0);
    check("remu_zero_const", 64'(rf[6]), 64'h0000_1234);
    do_op("rd0_mul", 2'd0, 5'd0, 32'd3, 32'd4);

    // start held high, operands changed during RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.rd = 5'd7; bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk);
    #1;
    bus.op = 2'd3; bus.rd = 5'd8; bus.A = 32'd50; bus.B = 32'd8;
    wait_done(k, busy_ok);
    check_done("hold_first", k, busy_ok, 5'd7, 32'd3000);
    @(posedge clk);
    #1;
    check("hold_gap_busy_low", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    check("hold_second_accept", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;
    wait_done(k, busy_ok);
    check_done("hold_second", k, busy_ok, 5'd8, ref_result(2'd3, 32'd50, 32'd8));
    @(posedge clk);
    #1;

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      r = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d_op%0d", i, o), o, r, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative unsigned multiply/divide unit for the lab CPU datapath, sitting between the register-file read ports and the register-file write port. It latches two 32-bit operands read from the register file, runs a 32-step shift-add multiply or restoring divide, and drives a one-cycle write-back (Reg_Write / W_Addr / W_Data) straight into the register file. It shares the register file's clock, so the result is written on the edge that ends the DONE cycle.

## Interface
Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- STEPS, 32, iterations per operation. Must equal XLEN.

Ports:
- clk_rst  in  1  asynchronous reset, active-low.
- clk_Regs  in  1  clock, rising edge, shared with the register file.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation select:
  - 00 MUL: low 32 bits of the product.
  - 01 MULHU: high 32 bits of the product.
  - 10 DIVU: quotient.
  - 11 REMU: remainder.
- rd  in  5  destination register, latched with start.
- A  in  32  operand A (R_Data_A), latched with start.
- B  in  32  operand B (R_Data_B), latched with start.
- busy  out  1  high from the edge accepting start through the DONE cycle.
- done  out  1  one-cycle pulse in DONE.
- Reg_Write  out  1  register-file write enable; high in DONE only, and only when latched rd != 0.
- W_Addr  out  5  latched rd; valid in DONE.
- W_Data  out  32  result; valid in DONE.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. At that edge, latch op, rd, A, B and set cnt=0.
  - RUN -> DONE on the edge where cnt==31 completes.
  - DONE -> IDLE unconditionally on the next edge.
- Multiply (op[1]=0), unsigned shift-add over a 64-bit accumulator {hi, lo}:
  - Initialise hi=0, lo=A.
  - Each step: if lo[0], hi += B with a 33-bit sum whose carry is kept. Then shift {carry, hi, lo} right by 1.
  - After 32 steps {hi, lo} = A*B exactly, with no overflow loss.
- Divide (op[1]=1), restoring division:
  - Initialise rem=0, quo=A.
  - Each step: shift {rem, quo} left by 1 and trial-subtract B from rem with a 33-bit subtract. If there is no borrow, rem = difference and quo[0]=1; otherwise quo[0]=0.
- Divide by zero (B==0) follows RISC-V convention: DIVU result 0xFFFFFFFF, REMU result = A. The unit still takes the full 32 steps so latency is fixed.
- Result mux in DONE: MUL -> lo, MULHU -> hi, DIVU -> quo, REMU -> rem.
- start while busy=1 is ignored. A, B and rd changes during RUN have no effect.
- rd==0: done pulses and W_Data is valid, but Reg_Write stays 0.
- Reset (clk_rst=0, any state, including mid-RUN):
  - Immediately state=IDLE, cnt=0, busy=0, done=0, Reg_Write=0, W_Addr=0, W_Data=0, internal registers 0.
  - An aborted operation produces no write.

## Timing
- Reset values: every output 0.
- Start accepted at edge N (state IDLE, start=1):
  - busy=1 after N.
  - RUN covers edges N+1 .. N+32.
  - DONE cycle follows edge N+32: done=1, Reg_Write=1 (if rd!=0), W_Addr and W_Data valid.
  - The register file captures at edge N+33. busy, done and Reg_Write drop after N+33.
- Fixed latency: 33 clocks from accepting edge to write edge, independent of op and operand values.
- Back-to-back: start=1 during DONE is ignored. The next start is accepted no earlier than edge N+34, so the minimum issue interval is 34 clocks.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-RUN: MUL 7*6 started, clk_rst pulled low at cycle 10 -> all outputs 0 at once; after release no Reg_Write ever asserts; a new MUL 7*6 then writes 42.
- MUL / MULHU, A=0xFFFFFFFF, B=0xFFFFFFFF, rd=5:
  - MUL -> W_Data=0x00000001, W_Addr=5, Reg_Write=1 exactly at the 33rd edge after start.
  - MULHU -> W_Data=0xFFFFFFFE.
- DIVU / REMU, A=100, B=7, rd=3 -> DIVU gives 14, REMU gives 2. A=0x80000000, B=1 -> DIVU gives 0x80000000.
- Divide by zero, A=0x1234, B=0:
  - DIVU -> 0xFFFFFFFF.
  - REMU -> 0x00001234.
  - Latency is still 33.
- start held high continuously with operands changed during RUN -> result uses the first latched operands; the second op is accepted exactly 34 edges after the first; busy drops for exactly 1 cycle between them.
- rd=0, MUL 3*4 -> done pulses with W_Data=12 while Reg_Write stays 0; x0 reads 0 afterwards.
